// File: rtl/flash_pkg.sv
// Shared types and defaults for the parallel-NOR flash responder.
package flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_DRIVE,
        PROG_WAIT,
        PROG_DONE
    } state_e;

    localparam logic [15:0] ERASED_WORD = 16'hFFFF;
    localparam int unsigned READ_CYCLES_DEF = 10;
    localparam int unsigned PROG_CYCLES_DEF = 4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Saturating access timer with clear/enable and a read/program terminal count.
module access_timer #(
    parameter int unsigned TW       = 5,
    parameter int unsigned READ_LIM = 10,
    parameter int unsigned PROG_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic sel_prog_i,
    output logic tc_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [TW-1:0] lim;

    assign lim  = sel_prog_i ? TW'(PROG_LIM - 1) : TW'(READ_LIM - 1);
    assign tc_o = (cnt_q >= lim);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flash_responder.sv
// NOR flash target: timed reads, AND-only program cycles into a word array.
module flash_responder
    import flash_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned READ_CYCLES = READ_CYCLES_DEF,
    parameter int unsigned PROG_CYCLES = PROG_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_n,
    input  logic              oe_n,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              bus_err
);

    localparam int unsigned TW = $clog2(max2(READ_CYCLES, PROG_CYCLES)) + 1;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] ERASED = DATA_W'(ERASED_WORD);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] dout_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic rd, pg, ill;
    logic clr, en, tc;
    logic latch_a, latch_d, commit, load_out;
    logic mapped;
    logic [IW-1:0] idx;

    assign rd  = !ce_n && !oe_n &&  we_n;
    assign pg  = !ce_n &&  oe_n && !we_n;
    assign ill = !ce_n && !oe_n && !we_n;

    assign mapped = (addr_q < ADDR_W'(DEPTH));
    assign idx    = addr_q[IW-1:0];

    access_timer #(
        .TW       (TW),
        .READ_LIM (READ_CYCLES),
        .PROG_LIM (PROG_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .en_i       (en),
        .sel_prog_i (state_q == PROG_WAIT),
        .tc_o       (tc)
    );

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        en       = 1'b0;
        latch_a  = 1'b0;
        latch_d  = 1'b0;
        commit   = 1'b0;
        load_out = 1'b0;
        err_d    = 1'b0;
        // Illegal strobes abort any cycle in flight.
        if (ill) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rd) begin
                        latch_a = 1'b1;
                        clr     = 1'b1;
                        state_d = READ_WAIT;
                    end else if (pg) begin
                        latch_a = 1'b1;
                        latch_d = 1'b1;
                        clr     = 1'b1;
                        state_d = PROG_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (!rd) begin
                        state_d = IDLE;
                    end else if (address != addr_q) begin
                        latch_a = 1'b1;
                        clr     = 1'b1;
                    end else if (tc) begin
                        load_out = 1'b1;
                        state_d  = READ_DRIVE;
                    end else begin
                        en = 1'b1;
                    end
                end
                READ_DRIVE: begin
                    if (!rd) begin
                        state_d = IDLE;
                    end else if (address != addr_q) begin
                        latch_a = 1'b1;
                        clr     = 1'b1;
                        state_d = READ_WAIT;
                    end
                end
                PROG_WAIT: begin
                    if (!pg) begin
                        state_d = IDLE;
                    end else if (tc) begin
                        commit  = mapped;
                        err_d   = !mapped;
                        state_d = PROG_DONE;
                    end else begin
                        en = 1'b1;
                    end
                end
                PROG_DONE: begin
                    if (we_n || ce_n) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (latch_a) addr_q <= address;
            if (latch_d) data_q <= data_in;
            if (load_out) dout_q <= mapped ? mem_q[idx] : ERASED;
        end
    end

    // Flash program semantics: bits can only be cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= ERASED;
            end
        end else if (commit) begin
            mem_q[idx] <= mem_q[idx] & data_q;
        end
    end

    assign data_valid = (state_q == READ_DRIVE);
    assign data_out   = data_valid ? dout_q : '0;
    assign busy       = (state_q == READ_WAIT) || (state_q == READ_DRIVE)
                        || (state_q == PROG_WAIT);
    assign bus_err    = err_q;

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: program vector table plus timed read sequences.
module tb_flash_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_n, oe_n, we_n;
    logic [15:0] address, data_in;
    logic [15:0] data_out;
    logic        data_valid, busy, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ce_n       (ce_n),
        .oe_n       (oe_n),
        .we_n       (we_n),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic        ce, oe, we;
        logic [15:0] a, d;
        logic        v;
        logic [15:0] q;
        logic        b, e;
    } vec_t;

    vec_t tab[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic o, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        ce_n = c;
        oe_n = o;
        we_n = w;
        address = a;
        data_in = d;
    endtask

    function automatic vec_t mk(input logic c, input logic o, input logic w,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic v, input logic [15:0] q,
                                input logic b, input logic e);
        vec_t t;
        t.ce = c; t.oe = o; t.we = w; t.a = a; t.d = d;
        t.v = v; t.q = q; t.b = b; t.e = e;
        return t;
    endfunction

    // Program addr/data: busy for 4 edges, commit on the 5th, then release.
    task automatic add_prog(input logic [15:0] a, input logic [15:0] d, input logic ue);
        for (int i = 0; i < 4; i++) tab.push_back(mk(0, 1, 0, a, d, 0, 0, 1, 0));
        tab.push_back(mk(0, 1, 0, a, d, 0, 0, 0, ue));
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
        int n;
        drive(0, 0, 1, a, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_valid && n < 30);
        chk({nm, " latency"}, n, 11);
        chk({nm, " data"}, data_out, exp);
        tick();
        chk({nm, " held"}, {data_valid, data_out}, {1'b1, exp});
        drive(1, 1, 1, 0, 0);
        tick();
        chk({nm, " release"}, {data_valid, data_out, busy}, 0);
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1;
        drive(1, 1, 1, 0, 0);
        tick();
        tick();
        chk("reset outs", {data_valid, data_out, busy, bus_err}, 0);
        rst = 1'b0;

        add_prog(16'd5, 16'h000B, 0);
        add_prog(16'd5, 16'h00F0, 0);
        tab.push_back(mk(0, 1, 0, 16'd4, 16'hFFF0, 0, 0, 1, 0));
        tab.push_back(mk(0, 1, 0, 16'd4, 16'hFFF0, 0, 0, 1, 0));
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 16'd7, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
        add_prog(16'd100, 16'h0000, 1);
        add_prog(16'd2, 16'h1234, 0);

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].ce, tab[i].oe, tab[i].we, tab[i].a, tab[i].d);
            tick();
            chk($sformatf("vec%0d", i), {data_valid, data_out, busy, bus_err},
                {tab[i].v, tab[i].q, tab[i].b, tab[i].e});
        end

        rd_chk("rd a3", 16'd3, 16'hFFFF);
        rd_chk("rd a5", 16'd5, 16'h0000);
        rd_chk("rd a4", 16'd4, 16'hFFFF);
        rd_chk("rd a2", 16'd2, 16'h1234);
        rd_chk("rd a100", 16'd100, 16'hFFFF);

        drive(0, 0, 1, 16'd1, 0);
        repeat (6) tick();
        chk("chg wait", {data_valid, busy}, 2'b01);
        address = 16'd2;
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_valid && n < 30);
        chk("chg latency", n, 11);
        chk("chg data", data_out, 16'h1234);
        drive(1, 1, 1, 0, 0);
        tick();

        drive(0, 0, 1, 16'd3, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!data_valid && n < 30);
        chk("drv valid", data_valid, 1);
        drive(0, 0, 0, 16'd3, 0);
        tick();
        chk("ill drive", {data_valid, data_out, busy, bus_err}, 1);
        drive(1, 1, 1, 0, 0);
        tick();
        chk("ill clear", {data_valid, busy, bus_err}, 0);

        drive(0, 0, 1, 16'd3, 0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("rst mid", {data_valid, busy, bus_err}, 0);
        rst = 1'b0;
        drive(1, 1, 1, 0, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= data_valid;
        end
        chk("rst no valid", seen, 0);

        rd_chk("rd a5 erased", 16'd5, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
